// File: rtl/i2c_passthru_pkg.sv
// Shared definitions for the I2C passthru: sequencer state encoding, bit-index
// constants and transfer-direction helpers.
package i2c_passthru_pkg;

  localparam int unsigned BIT_IDX_W = 4;
  localparam logic [BIT_IDX_W-1:0] ACK_BIT_IDX = 4'd8;
  localparam logic [BIT_IDX_W-1:0] LAST_DATA_BIT_IDX = 4'd7;

  localparam logic DIR_TO_SLV = 1'b0;
  localparam logic DIR_TO_MST = 1'b1;

  typedef enum logic [2:0] {
    ST_DS_IDLE      = 3'd0,
    ST_DS_ADDR      = 3'd1,
    ST_DS_DATA      = 3'd2,
    ST_DS_WAIT_STOP = 3'd3,
    ST_DS_FAULT     = 3'd4
  } ds_state_e;

  // Only a read data byte reverses the usual "bits to slave, ACK to master" flow.
  function automatic logic dir_for(input ds_state_e st, input logic rw,
                                   input logic [BIT_IDX_W-1:0] idx);
    logic is_ack;
    is_ack = (idx == ACK_BIT_IDX);
    if ((st == ST_DS_DATA) && rw) begin
      return is_ack ? DIR_TO_SLV : DIR_TO_MST;
    end
    return is_ack ? DIR_TO_MST : DIR_TO_SLV;
  endfunction

endpackage

// File: rtl/i2c_passthru_ref_timer.sv
// Loadable down-counter advanced by rising edges of a slow reference; emits a
// one-cycle pulse when an enabled decrement reaches zero.
module i2c_passthru_ref_timer #(
  parameter int unsigned LOAD_VAL = 200,
  parameter int unsigned CNT_W    = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_f_ref,
  input  logic i_load,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic             f_ref_q;
  logic             f_ref_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  assign f_ref_rise = i_f_ref & ~f_ref_q;

  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (i_load) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && f_ref_rise && (cnt_q != '0)) begin
      cnt_d     = CNT_W'(cnt_q - 1'b1);
      expired_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      f_ref_q   <= 1'b0;
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      f_ref_q   <= i_f_ref;
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign o_expired = expired_q;

endmodule

// File: rtl/i2c_passthru_dir_seq.sv
// Bit/byte sequencer: tracks the byte framing after START, picks the direction
// of each bit, hands start requests to the bit transmitter and watches for faults.
module i2c_passthru_dir_seq
  import i2c_passthru_pkg::*;
#(
  parameter int unsigned F_REF_T_STALL       = 200,
  parameter int unsigned WIDTH_F_REF_T_STALL = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_f_ref,
  input  logic       i_start_det,
  input  logic       i_stop_det,
  input  logic       i_bit_begin,
  input  logic       i_bit_end,
  input  logic       i_bit_val,
  input  logic       i_tx_done,
  input  logic       i_tx_violation,
  input  logic       i_fault_clr,
  output logic       o_start_tx,
  output logic       o_tx_is_to_mst,
  output logic [3:0] o_bit_idx,
  output logic       o_rw,
  output logic       o_is_addr,
  output logic       o_nack,
  output logic       o_fault
);

  ds_state_e            state_q, state_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic                 rw_q, rw_d;
  logic                 is_addr_q, is_addr_d;
  logic                 dir_q, dir_d;
  logic                 pending_q, pending_d;
  logic                 start_tx_q, start_tx_d;
  logic                 nack_q, nack_d;
  logic                 fault_q, fault_d;

  logic live_q;
  logic waiting;
  logic tmr_load;
  logic tmr_clr;
  logic tmr_expired;
  logic stall_fault;

  assign live_q      = (state_q == ST_DS_ADDR) || (state_q == ST_DS_DATA);
  assign waiting     = ~i_tx_done | pending_q;
  // The cycle right after a start request is exempt so the transmitter can drop done.
  assign tmr_clr     = ~live_q | (~waiting & ~start_tx_q);
  assign stall_fault = tmr_expired & live_q;

  i2c_passthru_ref_timer #(
    .LOAD_VAL (F_REF_T_STALL),
    .CNT_W    (WIDTH_F_REF_T_STALL)
  ) u_stall_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_f_ref   (i_f_ref),
    .i_load    (tmr_load),
    .i_clr     (tmr_clr),
    .i_en      (waiting),
    .o_expired (tmr_expired)
  );

  // Next-state: violation/stall > STOP > START > bit end > bit begin.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    rw_d       = rw_q;
    is_addr_d  = is_addr_q;
    dir_d      = dir_q;
    pending_d  = pending_q;
    start_tx_d = 1'b0;
    nack_d     = 1'b0;
    fault_d    = 1'b0;
    tmr_load   = 1'b0;

    if (state_q == ST_DS_FAULT) begin
      fault_d   = 1'b1;
      pending_d = 1'b0;
      if (!i_tx_violation && i_fault_clr) begin
        state_d   = ST_DS_IDLE;
        fault_d   = 1'b0;
        bit_idx_d = '0;
        is_addr_d = 1'b0;
        dir_d     = DIR_TO_SLV;
      end
    end else if ((state_q != ST_DS_IDLE) && (i_tx_violation || stall_fault)) begin
      state_d   = ST_DS_FAULT;
      fault_d   = 1'b1;
      pending_d = 1'b0;
    end else if (i_stop_det) begin
      state_d   = ST_DS_IDLE;
      bit_idx_d = '0;
      is_addr_d = 1'b0;
      dir_d     = DIR_TO_SLV;
      pending_d = 1'b0;
    end else if (i_start_det) begin
      state_d   = ST_DS_ADDR;
      bit_idx_d = '0;
      is_addr_d = 1'b1;
      dir_d     = DIR_TO_SLV;
      pending_d = 1'b0;
    end else if (live_q) begin
      if (i_bit_end) begin
        if (bit_idx_q == ACK_BIT_IDX) begin
          bit_idx_d = '0;
          if (i_bit_val) begin
            nack_d    = 1'b1;
            state_d   = ST_DS_WAIT_STOP;
            pending_d = 1'b0;
          end else begin
            state_d   = ST_DS_DATA;
            is_addr_d = 1'b0;
          end
        end else begin
          bit_idx_d = BIT_IDX_W'(bit_idx_q + 1'b1);
          if ((state_q == ST_DS_ADDR) && (bit_idx_q == LAST_DATA_BIT_IDX)) begin
            rw_d = i_bit_val;
          end
        end
        dir_d = dir_for(state_d, rw_d, bit_idx_d);
      end

      // Start handshake sees the post-bit-end state and direction.
      if ((state_d == ST_DS_ADDR) || (state_d == ST_DS_DATA)) begin
        if (i_bit_begin) begin
          if (pending_q) begin
            state_d   = ST_DS_FAULT;
            fault_d   = 1'b1;
            pending_d = 1'b0;
          end else if (i_tx_done) begin
            start_tx_d = 1'b1;
            tmr_load   = 1'b1;
          end else begin
            pending_d = 1'b1;
            tmr_load  = 1'b1;
          end
        end else if (pending_q && i_tx_done) begin
          start_tx_d = 1'b1;
          pending_d  = 1'b0;
          tmr_load   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_DS_IDLE;
      bit_idx_q  <= '0;
      rw_q       <= 1'b0;
      is_addr_q  <= 1'b0;
      dir_q      <= DIR_TO_SLV;
      pending_q  <= 1'b0;
      start_tx_q <= 1'b0;
      nack_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      rw_q       <= rw_d;
      is_addr_q  <= is_addr_d;
      dir_q      <= dir_d;
      pending_q  <= pending_d;
      start_tx_q <= start_tx_d;
      nack_q     <= nack_d;
      fault_q    <= fault_d;
    end
  end

  assign o_start_tx     = start_tx_q;
  assign o_tx_is_to_mst = dir_q;
  assign o_bit_idx      = bit_idx_q;
  assign o_rw           = rw_q;
  assign o_is_addr      = is_addr_q;
  assign o_nack         = nack_q;
  assign o_fault        = fault_q;

endmodule

// File: tb/tb_i2c_passthru_dir_seq.sv
// Scoreboard bench for i2c_passthru_dir_seq: a bit-stream model predicts each
// start request, NACK pulse and fault; a negedge monitor pops and compares.
module tb_i2c_passthru_dir_seq;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_f_ref = 1'b0;
  logic       i_start_det = 1'b0;
  logic       i_stop_det = 1'b0;
  logic       i_bit_begin = 1'b0;
  logic       i_bit_end = 1'b0;
  logic       i_bit_val = 1'b0;
  logic       i_tx_done = 1'b1;
  logic       i_tx_violation = 1'b0;
  logic       i_fault_clr = 1'b0;
  logic       o_start_tx;
  logic       o_tx_is_to_mst;
  logic [3:0] o_bit_idx;
  logic       o_rw;
  logic       o_is_addr;
  logic       o_nack;
  logic       o_fault;

  i2c_passthru_dir_seq #(
    .F_REF_T_STALL       (4),
    .WIDTH_F_REF_T_STALL (3)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_f_ref        (i_f_ref),
    .i_start_det    (i_start_det),
    .i_stop_det     (i_stop_det),
    .i_bit_begin    (i_bit_begin),
    .i_bit_end      (i_bit_end),
    .i_bit_val      (i_bit_val),
    .i_tx_done      (i_tx_done),
    .i_tx_violation (i_tx_violation),
    .i_fault_clr    (i_fault_clr),
    .o_start_tx     (o_start_tx),
    .o_tx_is_to_mst (o_tx_is_to_mst),
    .o_bit_idx      (o_bit_idx),
    .o_rw           (o_rw),
    .o_is_addr      (o_is_addr),
    .o_nack         (o_nack),
    .o_fault        (o_fault)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic        dir;
    logic [3:0]  idx;
    logic        addr;
    logic        rw;
  } start_t;
  typedef struct packed {
    logic [31:0] cyc;
    logic        addr;
  } nack_t;
  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } fault_t;

  start_t start_q[$];
  nack_t  nack_q[$];
  fault_t fault_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the byte framing seen by the sequencer
  int   m_idx  = 0;
  bit   m_addr = 0;
  bit   m_rw   = 0;
  bit   m_live = 0;

  function automatic bit m_dir();
    bit ack;
    ack = (m_idx == 8);
    if (!m_addr && m_rw) return !ack;
    return ack;
  endfunction

  task automatic m_end(input bit v);
    if (!m_live) return;
    if (m_idx == 8) begin
      m_idx = 0;
      if (v) begin
        nack_t n;
        n.cyc  = cyc + 1;
        n.addr = m_addr;
        nack_q.push_back(n);
        m_live = 0;
      end else begin
        m_addr = 0;
      end
    end else begin
      if (m_addr && m_idx == 7) m_rw = v;
      m_idx++;
    end
  endtask

  task automatic m_begin();
    start_t s;
    if (!m_live || !i_tx_done) return;
    s.cyc  = cyc + 1;
    s.dir  = m_dir();
    s.idx  = 4'(m_idx);
    s.addr = m_addr;
    s.rw   = m_rw;
    start_q.push_back(s);
  endtask

  task automatic m_idle();
    m_live = 0;
    m_idx  = 0;
    m_addr = 0;
  endtask

  // Monitor: every output event must match the head of its queue
  bit fault_prev = 0;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_start_tx) begin
        if (start_q.size() == 0) chk("start_tx_spurious", o_start_tx, 1'b0);
        else begin
          start_t e;
          e = start_q.pop_front();
          chk("start_tx", {cyc, o_tx_is_to_mst, o_bit_idx, o_is_addr, o_rw}, e);
        end
      end
      if (o_nack) begin
        if (nack_q.size() == 0) chk("nack_spurious", o_nack, 1'b0);
        else begin
          nack_t e;
          e = nack_q.pop_front();
          chk("nack", {cyc, o_is_addr, o_bit_idx}, {e.cyc, e.addr, 4'd0});
        end
      end
      if (o_fault && !fault_prev) begin
        if (fault_q.size() == 0) chk("fault_spurious", o_fault, 1'b0);
        else begin
          fault_t e;
          e = fault_q.pop_front();
          n_cmp++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_bad++;
            $display("FAIL fault_time: rose at cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
          end
        end
      end
    end
    fault_prev = o_fault;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_cycle(input bit b, input bit e, input bit v);
    i_bit_begin = b;
    i_bit_end   = e;
    i_bit_val   = v;
    if (e) m_end(v);
    if (b) m_begin();
    tick();
    i_bit_begin = 1'b0;
    i_bit_end   = 1'b0;
    i_bit_val   = 1'b0;
  endtask

  task automatic do_start();
    i_start_det = 1'b1;
    m_live = 1; m_idx = 0; m_addr = 1;
    tick();
    i_start_det = 1'b0;
  endtask

  task automatic do_stop();
    i_stop_det = 1'b1;
    m_idle();
    tick();
    i_stop_det = 1'b0;
  endtask

  task automatic do_fault_clr();
    i_fault_clr = 1'b1;
    m_idle();
    tick();
    i_fault_clr = 1'b0;
    chk("fault_cleared", o_fault, 1'b0);
  endtask

  logic [7:0] tx_bytes[$];
  logic       tx_acks[$];

  // START followed by tx_bytes; stops driving after a NACK
  task automatic run_txn(input bit merge_en);
    bit merged, stop_now;
    merged   = 0;
    stop_now = 0;
    do_start();
    for (int k = 0; k < tx_bytes.size() && !stop_now; k++) begin
      for (int i = 0; i < 9 && !stop_now; i++) begin
        logic [7:0] byt;
        bit v, last, mnext;
        byt   = tx_bytes[k];
        v     = (i < 8) ? byt[7-i] : tx_acks[k];
        last  = (k == tx_bytes.size() - 1) && (i == 8);
        if (!merged) drive_cycle(1'b1, 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) tick();
        mnext = merge_en && !last && ($urandom_range(0, 3) == 0);
        drive_cycle(mnext, 1'b1, v);
        merged = mnext;
        if (i == 8 && v) stop_now = 1;
      end
    end
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rw;
    int nd;

    // Reset values
    tick();
    chk("rst_start_tx", o_start_tx, 1'b0);
    chk("rst_dir", o_tx_is_to_mst, 1'b0);
    chk("rst_bit_idx", o_bit_idx, 4'd0);
    chk("rst_rw", o_rw, 1'b0);
    chk("rst_is_addr", o_is_addr, 1'b0);
    chk("rst_nack", o_nack, 1'b0);
    chk("rst_fault", o_fault, 1'b0);
    @(posedge i_clk); #3; i_rst = 1'b0;
    tick();

    // Write 0xA0 then 0x55, both ACKed
    tx_bytes = '{8'hA0, 8'h55};
    tx_acks  = '{1'b0, 1'b0};
    run_txn(1'b0);
    chk("write_rw", o_rw, 1'b0);
    chk("write_is_addr_after_data", o_is_addr, 1'b0);
    do_stop();
    chk("idle_bit_idx", o_bit_idx, 4'd0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (2) tick();

    // Read 0xA1, data byte, master NACK
    tx_bytes = '{8'hA1, 8'h3C};
    tx_acks  = '{1'b0, 1'b1};
    run_txn(1'b0);
    chk("read_rw", o_rw, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    do_stop();

    // Address NACK then repeated START from WAIT_STOP
    tx_bytes = '{8'hA0};
    tx_acks  = '{1'b1};
    run_txn(1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    do_start();
    chk("rstart_bit_idx", o_bit_idx, 4'd0);
    chk("rstart_is_addr", o_is_addr, 1'b1);
    do_stop();

    // Pending start released by done rising 5 cycles later
    do_start();
    i_tx_done = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    i_tx_done = 1'b1;
    begin
      start_t s;
      s.cyc = cyc + 1; s.dir = 1'b0; s.idx = 4'd0; s.addr = 1'b1; s.rw = m_rw;
      start_q.push_back(s);
    end
    repeat (3) tick();
    // Second begin while pending faults
    i_tx_done = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    fault_q.push_back('{lo: cyc + 1, hi: cyc + 1});
    drive_cycle(1'b1, 1'b0, 1'b0);
    tick();
    chk("pending_fault", o_fault, 1'b1);
    i_tx_done = 1'b1;
    do_fault_clr();

    // Stall: done held low after the start request
    do_start();
    drive_cycle(1'b1, 1'b0, 1'b0);
    i_tx_done = 1'b0;
    for (int e = 0; e < 3; e++) begin
      i_f_ref = 1'b1; repeat (2) tick();
      i_f_ref = 1'b0; repeat (2) tick();
    end
    chk("stall_no_fault_yet", o_fault, 1'b0);
    fault_q.push_back('{lo: cyc + 1, hi: cyc + 3});
    i_f_ref = 1'b1; repeat (2) tick();
    i_f_ref = 1'b0; repeat (3) tick();
    chk("stall_fault", o_fault, 1'b1);
    i_tx_done = 1'b1;
    do_fault_clr();
    drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (2) tick();

    // Transmitter violation
    do_start();
    i_tx_violation = 1'b1;
    fault_q.push_back('{lo: cyc + 1, hi: cyc + 1});
    tick();
    i_tx_violation = 1'b0;
    tick();
    do_fault_clr();

    // Random transactions with merged end/begin and repeated STARTs
    for (int t = 0; t < 25; t++) begin
      rw = 1'($urandom_range(0, 1));
      nd = $urandom_range(1, 3);
      tx_bytes.delete();
      tx_acks.delete();
      tx_bytes.push_back({7'($urandom), rw});
      tx_acks.push_back($urandom_range(0, 5) == 0);
      for (int j = 0; j < nd; j++) begin
        tx_bytes.push_back(8'($urandom));
        tx_acks.push_back(rw ? (j == nd - 1) : ($urandom_range(0, 4) == 0));
      end
      run_txn(1'b1);
      if ($urandom_range(0, 2) != 0) do_stop();
      repeat ($urandom_range(0, 3)) tick();
    end
    do_stop();

    // Async reset mid data byte at bit 5 of a read
    do_start();
    for (int i = 0; i < 14; i++) begin
      logic [8:0] bits;
      bits = {8'hA1, 1'b0};
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b1, (i < 9) ? bits[8-i] : 1'b1);
    end
    tick();
    chk("pre_rst_bit_idx", o_bit_idx, 4'd5);
    chk("pre_rst_dir", o_tx_is_to_mst, 1'b1);
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    m_idle();
    m_rw = 0;
    #1;
    chk("async_rst_outputs",
        {o_start_tx, o_tx_is_to_mst, o_bit_idx, o_rw, o_is_addr, o_nack, o_fault}, 10'd0);
    repeat (2) tick();
    @(posedge i_clk); #3; i_rst = 1'b0;
    tick();
    drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    chk("post_rst_bit_idx", o_bit_idx, 4'd0);

    repeat (3) tick();
    chk("start_q_left", 64'(start_q.size()), 64'd0);
    chk("nack_q_left", 64'(nack_q.size()), 64'd0);
    chk("fault_q_left", 64'(fault_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_passthru_dir_seq.md
Name: i2c_passthru_dir_seq

Overview:
- Bit/byte sequencer that drives one i2c_passthru_bittx instance per transfer direction.
- Tracks START/STOP, the bit index within a byte and the R/W bit, and decides per bit whether the bit goes to master or slave.
- Issues the single-cycle start request toward the bit transmitter, and watches for transfer faults and stalls.
- Sits between the bus-condition/bit-receive front end and the bit transmitter inside the passthru top.

Parameters:
- F_REF_T_STALL, 200: i_f_ref rising edges allowed between a bit start and the transmitter done; must be ≥2.
- WIDTH_F_REF_T_STALL, 8: CEILING(LOG2(F_REF_T_STALL+1)).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_f_ref  in  1  periodic timing reference; rising edges are counted.
- i_start_det  in  1  one-cycle pulse: START or repeated START detected on the master side.
- i_stop_det  in  1  one-cycle pulse: STOP detected.
- i_bit_begin  in  1  one-cycle pulse: source side has begun a new bit (SCL fell).
- i_bit_end  in  1  one-cycle pulse: source bit complete.
- i_bit_val  in  1  final sampled SDA of the bit; valid with i_bit_end.
- i_tx_done  in  1  bit transmitter idle/done.
- i_tx_violation  in  1  bit transmitter violation level.
- i_fault_clr  in  1  clears the FAULT state.
- o_start_tx  out  1  one-cycle request to the bit transmitter.
- o_tx_is_to_mst  out  1  direction of the current bit: 1 = slave→master.
- o_bit_idx  out  4  bit index within the byte; 0..7 are data bits, 8 is ACK.
- o_rw  out  1  latched R/W bit of the address byte.
- o_is_addr  out  1  current byte is the address byte.
- o_nack  out  1  one-cycle pulse when an ACK slot samples 1.
- o_fault  out  1  fault level.

Behaviour:
- Reset values: state IDLE, all outputs 0, bit_idx 0, pending 0, timer 0.
- All outputs are registered.
- States: IDLE, ADDR, DATA, WAIT_STOP, FAULT.
- IDLE: i_start_det → ADDR with bit_idx=0 and o_is_addr=1.
- ADDR/DATA, on each i_bit_end: bit_idx increments; from 8 it wraps to 0.
  - In ADDR at bit_idx 7: o_rw is latched from i_bit_val.
  - At bit_idx 8 with i_bit_val=1: pulse o_nack and go to WAIT_STOP.
  - At bit_idx 8 with i_bit_val=0: go to (or stay in) DATA with o_is_addr=0.
- Direction (o_tx_is_to_mst), updated the same cycle as bit_idx:
  - ADDR: 0 for bits 0–7, 1 for ACK.
  - DATA write (rw=0): 0 for bits 0–7, 1 for ACK.
  - DATA read (rw=1): 1 for bits 0–7, 0 for ACK.
- Start handshake:
  - i_bit_begin with i_tx_done=1 → o_start_tx=1 on the next cycle, for exactly one cycle.
  - i_bit_begin with i_tx_done=0 → set pending; o_start_tx is issued the cycle after i_tx_done rises.
  - i_bit_begin while pending → FAULT.
- No start requests are issued in IDLE or WAIT_STOP.
- Stall timer:
  - Loads F_REF_T_STALL when o_start_tx or pending is set.
  - Decrements on each i_f_ref rising edge while i_tx_done=0 or pending.
  - Reaching 0 while still waiting → FAULT.
  - Idles at 0 otherwise.
- i_start_det in ADDR/DATA/WAIT_STOP: repeated START; go to ADDR, bit_idx=0, pending cleared.
- i_stop_det in any state except FAULT: go to IDLE, bit_idx=0.
- i_tx_violation=1 in any state except IDLE → FAULT.
- FAULT:
  - o_fault=1; all other pulses suppressed.
  - Leave only on i_fault_clr → IDLE.
- Priority on simultaneous events, highest first: i_rst, i_tx_violation, i_stop_det, i_start_det, i_bit_end, i_bit_begin.
- i_bit_end and i_bit_begin in the same cycle: bit_idx and direction update first; o_start_tx uses the new direction.
- i_rst asserted mid-byte: immediate return to reset values; no o_start_tx glitch.

Decomposition:
- Shared package i2c_passthru_pkg holds:
  - state encodings ST_DS_IDLE..ST_DS_FAULT;
  - ACK_BIT_IDX=8 and BIT_IDX_W=4;
  - direction constants DIR_TO_SLV=0 and DIR_TO_MST=1.
- Sub-module i2c_passthru_ref_timer: loadable down-counter clocked by i_f_ref rising edges, with terminal-count output. It implements the stall timer and can be reused elsewhere.

Test Plan:
- Write: START; address 0xA0 (bits 1,0,1,0,0,0,0,0), ACK=0; then data 0x55 and ACK=0; then STOP → direction 0×8,1 for each byte; o_rw=0; o_is_addr falls after the first ACK; IDLE after STOP.
- Read: address 0xA1, ACK=0, data byte → data bits give o_tx_is_to_mst=1; read ACK gives 0; master ACK=1 produces a one-cycle o_nack and WAIT_STOP; further i_bit_begin gives no o_start_tx.
- Address NACK: ACK slot i_bit_val=1 → o_nack for 1 cycle; WAIT_STOP; i_start_det returns to ADDR with bit_idx=0.
- Pending start: i_bit_begin while i_tx_done=0, then i_tx_done rises 5 cycles later → o_start_tx exactly 1 cycle after the rise; a second i_bit_begin while pending → o_fault=1.
- Stall: F_REF_T_STALL=4; i_tx_done held 0 after o_start_tx → o_fault asserted after the 4th i_f_ref rising edge; i_fault_clr → IDLE.
- Reset mid-byte at bit_idx=5 in DATA: assert i_rst asynchronously → all outputs 0 with no clock edge needed; after release, state is IDLE.
